// File: rtl/nco_sweep_ctrl_if.sv
// Configuration bus from the FX2LP register block into the NCO sweep sequencer.
// The host presents a whole frequency plan at once and qualifies it with cfg_valid.
interface nco_sweep_ctrl_if #(
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int DWELL_WIDTH       = 16
);
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [ACCUMULATOR_WIDTH-1:0] cfg_start;
  logic [ACCUMULATOR_WIDTH-1:0] cfg_stop;
  logic [ACCUMULATOR_WIDTH-1:0] cfg_step;
  logic [DWELL_WIDTH-1:0]       cfg_dwell;
  logic [1:0]                   cfg_mode;

  modport master (
    output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Drives NCO phase increment / clock enable / phase clear from a latched frequency plan:
// fixed tune, or single / sawtooth / triangle sweep with an exact per-frequency dwell.
module nco_sweep_ctrl #(
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int DWELL_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  nco_sweep_ctrl_if.slave              cfg,
  input  logic                         run,
  output logic [ACCUMULATOR_WIDTH-1:0] phi_inc_o,
  output logic                         nco_clken,
  output logic                         nco_phase_clr_n,
  output logic                         busy,
  output logic                         step_stb,
  output logic                         sweep_done
);
  localparam int AW = ACCUMULATOR_WIDTH;
  localparam int DW = DWELL_WIDTH;
  localparam logic [1:0] M_FIXED = 2'b00, M_SINGLE = 2'b01, M_SAW = 2'b10;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   sh_start, sh_stop, sh_step;
  logic [DW-1:0]   sh_dwell, dwell_cnt, dwell_nx;
  logic [1:0]      sh_mode;
  logic            dir_up, dir_nx, ready_q, accept;
  logic [AW-1:0]   phi_nx, target, mv_target, stepped;
  logic            natural_up, toward_stop, at_end, mv_up, stb_nx, done_nx;
  logic [AW:0]     sum, dif;

  assign cfg.cfg_ready = ready_q;
  assign accept        = cfg.cfg_valid & ready_q;
  assign natural_up    = sh_stop >= sh_start;

  // Heading toward stop when moving in the plan's natural direction; otherwise back toward start.
  always_comb begin
    toward_stop = (dir_up == natural_up);
    target      = toward_stop ? sh_stop : sh_start;
    at_end      = (phi_inc_o == target);
    mv_up       = dir_up;
    mv_target   = target;
    if (at_end && sh_mode == 2'b11) begin
      mv_up     = ~dir_up;
      mv_target = toward_stop ? sh_start : sh_stop;
    end
    sum     = {1'b0, phi_inc_o} + {1'b0, sh_step};
    dif     = {1'b0, phi_inc_o} - {1'b0, sh_step};
    stepped = mv_target;
    // Clamp on overshoot, carry/borrow or zero step; the increment never wraps.
    if (mv_up) begin
      if (!sum[AW] && sum[AW-1:0] <= mv_target && sh_step != '0) stepped = sum[AW-1:0];
    end else begin
      if (!dif[AW] && dif[AW-1:0] >= mv_target && sh_step != '0) stepped = dif[AW-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    phi_nx   = phi_inc_o;
    dwell_nx = dwell_cnt;
    dir_nx   = dir_up;
    stb_nx   = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: if (run && !accept) state_nx = ARM;
      ARM: begin
        if (!run) state_nx = IDLE;
        else begin
          state_nx = RUN;
          phi_nx   = sh_start;
          stb_nx   = 1'b1;
          dwell_nx = sh_dwell;
          dir_nx   = natural_up;
        end
      end
      RUN: begin
        if (!run) state_nx = IDLE;
        else if (dwell_cnt != '0) dwell_nx = dwell_cnt - 1'b1;
        else begin
          dwell_nx = sh_dwell;
          if (sh_mode != M_FIXED) begin
            if (at_end && sh_mode == M_SINGLE) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else if (at_end && sh_mode == M_SAW) begin
              phi_nx = sh_start;
              stb_nx = 1'b1;
            end else begin
              phi_nx = stepped;
              stb_nx = 1'b1;
              if (at_end) dir_nx = ~dir_up;
            end
          end
        end
      end
      DONE: if (!run) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      phi_inc_o       <= '0;
      dwell_cnt       <= '0;
      dir_up          <= 1'b1;
      step_stb        <= 1'b0;
      sweep_done      <= 1'b0;
      busy            <= 1'b0;
      nco_clken       <= 1'b0;
      nco_phase_clr_n <= 1'b0;
      ready_q         <= 1'b1;
    end else begin
      state           <= state_nx;
      phi_inc_o       <= phi_nx;
      dwell_cnt       <= dwell_nx;
      dir_up          <= dir_nx;
      step_stb        <= stb_nx;
      sweep_done      <= done_nx;
      busy            <= (state_nx == ARM) || (state_nx == RUN);
      nco_clken       <= (state_nx == RUN) || (state_nx == DONE);
      nco_phase_clr_n <= (state_nx == RUN) || (state_nx == DONE);
      ready_q         <= (state_nx == IDLE);
    end
  end

  // Shadow plan only loads through the handshake, which is open solely in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
      sh_mode  <= '0;
    end else if (accept) begin
      sh_start <= cfg.cfg_start;
      sh_stop  <= cfg.cfg_stop;
      sh_step  <= cfg.cfg_step;
      sh_dwell <= cfg.cfg_dwell;
      sh_mode  <= cfg.cfg_mode;
    end
  end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: table of sweep plans with hand-computed
// frequency sequences, plus hand sequences for reset, fixed mode and run abort.
module tb_nco_sweep_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [31:0] phi_inc_o;
  logic        nco_clken, nco_phase_clr_n, busy, step_stb, sweep_done;
  int          n_vec = 0, n_bad = 0;

  nco_sweep_ctrl_if #(.ACCUMULATOR_WIDTH(32), .DWELL_WIDTH(16)) cfg_bus ();

  nco_sweep_ctrl #(.ACCUMULATOR_WIDTH(32), .DWELL_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg(cfg_bus), .run(run),
    .phi_inc_o(phi_inc_o), .nco_clken(nco_clken), .nco_phase_clr_n(nco_phase_clr_n),
    .busy(busy), .step_stb(step_stb), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      start, stop, step;
    logic [15:0]      dwell;
    logic [1:0]       mode;
    logic [3:0]       n;
    logic             done;
    logic [7:0][31:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [31:0] s, p, st, input logic [15:0] d,
                              input logic [1:0] m, input int n, input logic dn,
                              input logic [31:0] e0, e1, e2 = 0, e3 = 0,
                              input logic [31:0] e4 = 0, e5 = 0, e6 = 0, e7 = 0);
    vec_t v;
    v.start = s; v.stop = p; v.step = st; v.dwell = d; v.mode = m;
    v.n = 4'(n); v.done = dn;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Present a plan together with run, then walk through the accept cycle and ARM into RUN.
  task automatic load_and_arm(input logic [31:0] s, p, st, input logic [15:0] d, input logic [1:0] m);
    cfg_bus.cfg_start = s; cfg_bus.cfg_stop = p; cfg_bus.cfg_step = st;
    cfg_bus.cfg_dwell = d; cfg_bus.cfg_mode = m;
    cfg_bus.cfg_valid = 1'b1;
    run = 1'b1;
    tick();
    chk("accept_busy", 32'(busy), 32'd0);
    cfg_bus.cfg_valid = 1'b0;
    tick();
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_clr_n", 32'(nco_phase_clr_n), 32'd0);
    chk("arm_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    tick();
  endtask

  initial begin
    vecs[0] = mk(100, 130, 10, 3, 2'b01, 4, 1'b1, 100, 110, 120, 130);
    vecs[1] = mk(100, 125, 10, 0, 2'b10, 8, 1'b0, 100, 110, 120, 125, 100, 110, 120, 125);
    vecs[2] = mk(0, 20, 10, 1, 2'b11, 8, 1'b0, 0, 10, 20, 10, 0, 10, 20, 10);
    vecs[3] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 2'b11, 4, 1'b0,
                 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    vecs[4] = mk(50, 20, 15, 0, 2'b01, 3, 1'b1, 50, 35, 20);
    vecs[5] = mk(50, 20, 0, 0, 2'b01, 2, 1'b1, 50, 20);
    vecs[6] = mk(7, 7, 5, 1, 2'b10, 3, 1'b0, 7, 7, 7);
    vecs[7] = mk(7, 7, 5, 0, 2'b01, 1, 1'b1, 7, 0);

    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_start = '0; cfg_bus.cfg_stop = '0; cfg_bus.cfg_step = '0;
    cfg_bus.cfg_dwell = '0; cfg_bus.cfg_mode = '0;
    reset_n = 1'b0;
    run     = 1'b1;

    // Reset held with run high: must stay idle across edges
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    chk("rst_clr_n", 32'(nco_phase_clr_n), 32'd0);
    chk("rst_clken", 32'(nco_clken), 32'd0);
    chk("rst_phi", phi_inc_o, 32'd0);
    chk("rst_stb", 32'(step_stb), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_arm", 32'(busy), 32'd1);
    run = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Table-driven sweeps
    for (int v = 0; v < 8; v++) begin
      run = 1'b0;
      tick();
      chk("idle_ready", 32'(cfg_bus.cfg_ready), 32'd1);
      chk("idle_clken", 32'(nco_clken), 32'd0);
      load_and_arm(vecs[v].start, vecs[v].stop, vecs[v].step, vecs[v].dwell, vecs[v].mode);
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        for (int c = 0; c <= int'(vecs[v].dwell); c++) begin
          chk($sformatf("v%0d_phi%0d", v, k), phi_inc_o, vecs[v].exp[k]);
          chk($sformatf("v%0d_stb%0d", v, k), 32'(step_stb), (c == 0) ? 32'd1 : 32'd0);
          tick();
        end
      end
      if (vecs[v].done) begin
        chk($sformatf("v%0d_done", v), 32'(sweep_done), 32'd1);
        chk($sformatf("v%0d_done_busy", v), 32'(busy), 32'd0);
        chk($sformatf("v%0d_done_clken", v), 32'(nco_clken), 32'd1);
        chk($sformatf("v%0d_done_clr", v), 32'(nco_phase_clr_n), 32'd1);
        chk($sformatf("v%0d_done_stb", v), 32'(step_stb), 32'd0);
        tick();
        chk($sformatf("v%0d_done_pulse", v), 32'(sweep_done), 32'd0);
        chk($sformatf("v%0d_done_hold", v), phi_inc_o, vecs[v].stop);
      end
    end

    // Fixed tune: never steps, one strobe at ARM only
    run = 1'b0;
    tick();
    load_and_arm(200, 300, 10, 1, 2'b00);
    for (int c = 0; c < 6; c++) begin
      chk("fixed_phi", phi_inc_o, 32'd200);
      chk("fixed_stb", 32'(step_stb), (c == 0) ? 32'd1 : 32'd0);
      tick();
    end

    // Abort mid-RUN with a config offered while busy
    run = 1'b0;
    tick();
    load_and_arm(100, 130, 10, 3, 2'b01);
    for (int c = 0; c < 5; c++) tick();
    chk("abort_phi_pre", phi_inc_o, 32'd110);
    cfg_bus.cfg_start = 999; cfg_bus.cfg_stop = 5; cfg_bus.cfg_mode = 2'b10;
    cfg_bus.cfg_valid = 1'b1;
    chk("busy_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    run = 1'b0;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_clken", 32'(nco_clken), 32'd0);
    chk("abort_clr_n", 32'(nco_phase_clr_n), 32'd0);
    chk("abort_phi_hold", phi_inc_o, 32'd110);
    chk("abort_no_done", 32'(sweep_done), 32'd0);
    chk("abort_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    run = 1'b1;
    tick();
    tick();
    chk("shadow_kept_phi", phi_inc_o, 32'd100);
    chk("shadow_kept_stb", 32'(step_stb), 32'd1);

    // Asynchronous reset mid-sweep clears shadow plan
    for (int c = 0; c < 5; c++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_phi", phi_inc_o, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clr_n", 32'(nco_phase_clr_n), 32'd0);
    chk("arst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    chk("arst_rearm", 32'(busy), 32'd1);
    tick();
    chk("arst_start0", phi_inc_o, 32'd0);
    chk("arst_clken", 32'(nco_clken), 32'd1);
    run = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Sequencer that drives the phase-increment, clock-enable and phase-clear inputs of the sine/cosine NCO in the SDR receive path.
- Host configuration arrives via the FX2LP register interface as a start/stop/step/dwell frequency plan. The block holds a fixed tune or steps a frequency sweep (single, sawtooth or triangle).
- Each frequency is held for an exact dwell count.

Parameters:
ACCUMULATOR_WIDTH, 32, width of phase-increment words (matches NCO accumulator)
DWELL_WIDTH, 16, width of dwell counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration word set valid
cfg_ready  out  1  block accepts configuration
cfg_start  in  ACCUMULATOR_WIDTH  first phase increment
cfg_stop  in  ACCUMULATOR_WIDTH  final phase increment
cfg_step  in  ACCUMULATOR_WIDTH  unsigned step magnitude
cfg_dwell  in  DWELL_WIDTH  hold time per frequency, in cycles minus 1
cfg_mode  in  2  00 fixed, 01 single sweep, 10 sawtooth repeat, 11 triangle repeat
run  in  1  level; high = sequence active
phi_inc_o  out  ACCUMULATOR_WIDTH  to NCO phi_inc_i
nco_clken  out  1  to NCO clken
nco_phase_clr_n  out  1  to NCO reset_n (active-low phase clear)
busy  out  1  high in ARM/RUN
step_stb  out  1  one-cycle pulse in the cycle phi_inc_o takes a new value
sweep_done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- All outputs and state are registered.
- Reset values: phi_inc_o=0, nco_clken=0, nco_phase_clr_n=0, busy=0, step_stb=0, sweep_done=0, cfg_ready=1. State=IDLE, shadow regs=0, dir=up, dwell_cnt=0.
- Config handshake:
  - cfg_ready=1 only in IDLE.
  - On cfg_valid&cfg_ready, all cfg_* are latched into shadow regs in the same edge.
  - cfg_* are ignored outside IDLE; shadow regs never change while busy.
- Direction: dir=up if shadow_stop >= shadow_start (unsigned), else down. Recomputed on ARM.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - nco_clken=0, nco_phase_clr_n=0, phi_inc_o holds its last value.
  - run=1 and no config accept in this cycle -> ARM.
  - If a config accept and run are simultaneous, the config is latched first and ARM is entered next cycle.
- ARM (exactly 1 cycle):
  - phi_inc_o<=start, step_stb=1, dwell_cnt<=dwell, nco_phase_clr_n stays 0.
  - Next state RUN.
- RUN:
  - nco_phase_clr_n=1, nco_clken=1; dwell_cnt decrements each cycle.
  - When dwell_cnt==0 and mode!=00: dwell_cnt<=dwell and the frequency updates on the same edge, so each frequency is presented for exactly dwell+1 cycles.
  - Mode 00: never steps; dwell_cnt free-runs and reloads.
- Frequency update rule:
  - If phi_inc_o==stop (or ==start when returning down in triangle), apply the end action.
  - Otherwise next = phi_inc_o ± step, computed in ACCUMULATOR_WIDTH+1 bits.
  - If the result passes the target, or carries/borrows out, or step==0, next = target (clamp, never wrap). step_stb=1 on every change.
- End actions:
  - Mode 01: go to DONE; sweep_done=1 for 1 cycle; phi_inc_o holds stop.
  - Mode 10: phi_inc_o<=start, step_stb=1, no phase clear.
  - Mode 11: dir inverts and stepping continues toward the other endpoint.
  - start==stop: mode 01 -> DONE after the first dwell; modes 10/11 reload the same value, with step_stb still pulsing each dwell.
- DONE:
  - NCO keeps running at stop (clken=1, clr_n=1); busy=0.
  - run=0 -> IDLE.
- run=0 in ARM or RUN -> IDLE on the next edge: clken=0, clr_n=0, phi_inc_o held, no sweep_done.
- Asynchronous reset mid-sweep: immediately restores reset values; the configuration must be reloaded.

Test Plan:
- Reset with run=1 -> IDLE, cfg_ready=1, nco_phase_clr_n=0, phi_inc_o=0; no ARM until reset is released.
- Load start=100, stop=130, step=10, dwell=3, mode=01; raise run -> ARM 1 cycle, then phi_inc_o = 100,110,120,130, each held 4 cycles. step_stb pulses 4 times; sweep_done pulses once, 16 cycles after RUN entry; DONE holds 130 with nco_clken=1.
- start=100, stop=125, step=10, mode=10, dwell=0 -> sequence 100,110,120,125,100,110,... (clamp at 125, no wrap).
- Triangle: start=0, stop=20, step=10, mode=11, dwell=1 -> 0,10,20,10,0,10,... each held 2 cycles. Then start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 -> clamps to 0xFFFFFFFF, no overflow wrap.
- Down sweep: start=50, stop=20, step=15, mode=01 -> 50,35,20 then DONE. With step=0 -> 50,20 then DONE.
- Drop run mid-RUN, and drive cfg_valid while busy -> IDLE next edge, clken=0, phi_inc_o held, cfg_ready=0 while busy, shadow regs unchanged. cfg_valid together with run in IDLE -> new config is used by ARM.
